// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator: counter width, CEA 720p60
// timing and a tiny timing set that keeps simulation frames short.
package video_timing_pkg;

    localparam int CNT_W         = 12;
    localparam int CNT_MAX_TOTAL = 1 << CNT_W;

    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;

    localparam int TEST_H_ACTIVE = 8;
    localparam int TEST_H_FP     = 2;
    localparam int TEST_H_SYNC   = 3;
    localparam int TEST_H_BP     = 3;
    localparam int TEST_V_ACTIVE = 4;
    localparam int TEST_V_FP     = 1;
    localparam int TEST_V_SYNC   = 2;
    localparam int TEST_V_BP     = 1;

    function automatic int span_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// Enable in, raster coordinates and sync/enable decodes out; master is the
// timing generator, slave is whatever consumes the raster.
interface video_timing_if;
    import video_timing_pkg::*;

    logic             i_en;
    logic [CNT_W-1:0] o_hcnt;
    logic [CNT_W-1:0] o_vcnt;
    logic             o_hsync;
    logic             o_vsync;
    logic             o_de;
    logic             o_line_start;
    logic             o_frame_start;

    modport master (
        input  i_en,
        output o_hcnt, o_vcnt, o_hsync, o_vsync, o_de, o_line_start, o_frame_start
    );

    modport slave (
        output i_en,
        input  o_hcnt, o_vcnt, o_hsync, o_vsync, o_de, o_line_start, o_frame_start
    );

endinterface

// File: rtl/video_timing_gen_wrap_counter.sv
// Counter 0..MAX that resets to MAX, so the first increment lands on 0.
// wrap flags the terminal count so a cascaded counter can step on it.
module wrap_counter #(
    parameter int MAX = 15,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         wrap
);
    localparam logic [W-1:0] LAST = W'(MAX);

    logic [W-1:0] value_q, value_d;

    assign wrap  = (value_q == LAST);
    assign value = value_q;

    always_comb begin
        value_d = value_q;
        if (inc) value_d = wrap ? '0 : value_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) value_q <= LAST;
        else     value_q <= value_d;
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator. Decodes are computed from the next counter values
// and registered, so every output describes the current (hcnt, vcnt).
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_720P,
    parameter int H_FP     = H_FP_720P,
    parameter int H_SYNC   = H_SYNC_720P,
    parameter int H_BP     = H_BP_720P,
    parameter int V_ACTIVE = V_ACTIVE_720P,
    parameter int V_FP     = V_FP_720P,
    parameter int V_SYNC   = V_SYNC_720P,
    parameter int V_BP     = V_BP_720P,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1
) (
    input  logic           i_clk_74M,
    input  logic           i_rst,
    video_timing_if.master vif
);
    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > CNT_MAX_TOTAL || V_TOTAL > CNT_MAX_TOTAL ||
        H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_cfg
        $error("video_timing_gen: invalid timing parameters");
    end

    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hcnt, vcnt, h_d, v_d;
    logic             h_wrap, v_wrap, v_inc;
    logic             hs_d, vs_d, de_d, ls_d, fs_d;
    logic             hs_q, vs_q, de_q, ls_q, fs_q;

    assign v_inc = vif.i_en && h_wrap;

    wrap_counter #(.MAX(H_TOTAL - 1), .W(CNT_W)) u_hcnt (
        .clk   (i_clk_74M),
        .rst   (i_rst),
        .inc   (vif.i_en),
        .value (hcnt),
        .wrap  (h_wrap)
    );

    wrap_counter #(.MAX(V_TOTAL - 1), .W(CNT_W)) u_vcnt (
        .clk   (i_clk_74M),
        .rst   (i_rst),
        .inc   (v_inc),
        .value (vcnt),
        .wrap  (v_wrap)
    );

    // Mirror of the counters' next state so decodes line up with the counters.
    always_comb begin
        h_d = hcnt;
        v_d = vcnt;
        if (vif.i_en) h_d = h_wrap ? '0 : hcnt + CNT_W'(1);
        if (v_inc)    v_d = v_wrap ? '0 : vcnt + CNT_W'(1);
        de_d = (h_d < H_ACT) && (v_d < V_ACT);
        hs_d = ((h_d >= HS_BEG) && (h_d < HS_END)) ? H_POL : ~H_POL;
        vs_d = ((v_d >= VS_BEG) && (v_d < VS_END)) ? V_POL : ~V_POL;
        ls_d = vif.i_en && (h_d == '0);
        fs_d = ls_d && (v_d == '0);
    end

    always_ff @(posedge i_clk_74M or posedge i_rst) begin
        if (i_rst) begin
            hs_q <= ~H_POL;
            vs_q <= ~V_POL;
            de_q <= 1'b0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
        end
    end

    assign vif.o_hcnt        = hcnt;
    assign vif.o_vcnt        = vcnt;
    assign vif.o_hsync       = hs_q;
    assign vif.o_vsync       = vs_q;
    assign vif.o_de          = de_q;
    assign vif.o_line_start  = ls_q;
    assign vif.o_frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small-timing DUT checked every cycle against a
// linear-position raster model, plus a 720p DUT with inverted sync polarity.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam int HA = TEST_H_ACTIVE, HF = TEST_H_FP, HS = TEST_H_SYNC, HB = TEST_H_BP;
    localparam int VA = TEST_V_ACTIVE, VF = TEST_V_FP, VS = TEST_V_SYNC, VB = TEST_V_BP;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int NPIX = HT * VT;

    logic clk = 1'b0;
    logic rst;
    logic rst_hd;
    always #5 clk = ~clk;

    video_timing_if vif ();
    video_timing_if vhd ();

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b1), .V_POL(1'b1)
    ) dut (
        .i_clk_74M (clk),
        .i_rst     (rst),
        .vif       (vif)
    );

    video_timing_gen #(.H_POL(1'b0), .V_POL(1'b0)) dut_hd (
        .i_clk_74M (clk),
        .i_rst     (rst_hd),
        .vif       (vhd)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Model: raster position as a single linear index into the frame.
    int pos;
    bit adv;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= NPIX - 1;
            adv <= 1'b0;
        end else if (vif.i_en) begin
            pos <= (pos + 1) % NPIX;
            adv <= 1'b1;
        end else begin
            adv <= 1'b0;
        end
    end

    function automatic logic [28:0] model_out(input int p, input bit a);
        int h, v;
        h = p % HT;
        v = p / HT;
        return {12'(h), 12'(v),
                1'(h >= HA + HF && h < HA + HF + HS),
                1'(v >= VA + VF && v < VA + VF + VS),
                1'(h < HA && v < VA),
                1'(a && h == 0),
                1'(a && p == 0)};
    endfunction

    logic [28:0] act;
    assign act = {vif.o_hcnt, vif.o_vcnt, vif.o_hsync, vif.o_vsync, vif.o_de,
                  vif.o_line_start, vif.o_frame_start};

    always @(negedge clk) begin
        logic [28:0] want;
        want = model_out(pos, adv);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL model: got h=%0d v=%0d hs/vs/de/ls/fs=%b want h=%0d v=%0d hs/vs/de/ls/fs=%b (t=%0t)",
                     act[28:17], act[16:5], act[4:0], want[28:17], want[16:5], want[4:0], $time);
        end
    end

    // 720p with active-low syncs: hsync window and active pixels per line.
    int hd_cyc = 0;
    int hd_de  = 0;
    bit hd_seen = 1'b0;
    always @(negedge clk) begin
        if (hd_cyc < 3400) begin
            hd_cyc++;
            chk("hd_hsync", 32'(vhd.o_hsync),
                (vhd.o_hcnt >= 12'd1390 && vhd.o_hcnt < 12'd1430) ? 32'd0 : 32'd1);
            if (vhd.o_line_start) begin
                if (hd_seen) chk("hd_de_per_line", hd_de, 1280);
                hd_de   = int'(vhd.o_de);
                hd_seen = 1'b1;
            end else begin
                hd_de += int'(vhd.o_de);
            end
        end
    end

    task automatic wait_for(input int h, input int v, input int budget, input string nm);
        int n;
        n = 0;
        while (!(vif.o_hcnt == 12'(h) && (v < 0 || vif.o_vcnt == 12'(v))) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk({nm, "_timeout"}, 32'(n), 32'(budget - 1));
    endtask

    initial begin
        int last_fs, last_ls, v0;
        logic [15:0] hs_mask;
        logic [7:0]  vs_mask;
        bit prev_vs, prev_end, seen7, seen8;

        rst = 1'b1; rst_hd = 1'b1;
        vif.i_en = 1'b0; vhd.i_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hcnt", 32'(vif.o_hcnt), 15);
        chk("rst_vcnt", 32'(vif.o_vcnt), 7);
        chk("rst_flags", {27'd0, vif.o_hsync, vif.o_vsync, vif.o_de, vif.o_line_start, vif.o_frame_start}, 0);
        chk("hd_rst_syncs", {30'd0, vhd.o_hsync, vhd.o_vsync}, 32'h3);
        chk("hd_rst_cnt", {vhd.o_hcnt, 4'd0, vhd.o_vcnt}, {12'd1649, 4'd0, 12'd749});

        rst = 1'b0; rst_hd = 1'b0;
        @(negedge clk);
        chk("release_no_en", {vif.o_hcnt, 4'd0, vif.o_vcnt}, {12'd15, 4'd0, 12'd7});
        vif.i_en = 1'b1; vhd.i_en = 1'b1;

        last_fs = -1; last_ls = -1; hs_mask = '0; vs_mask = '0;
        prev_vs = 1'b0; prev_end = 1'b0; seen7 = 1'b0; seen8 = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 0)
                chk("first_cycle", {vif.o_hcnt, vif.o_vcnt, vif.o_de, vif.o_frame_start, vif.o_line_start},
                    {12'd0, 12'd0, 3'b111});
            if (prev_end)
                chk("wrap", {vif.o_hcnt, vif.o_vcnt, vif.o_frame_start}, {12'd0, 12'd0, 1'b1});
            if (vif.o_hcnt == 12'd7 && !seen7) begin chk("de_h7", 32'(vif.o_de), 1); seen7 = 1'b1; end
            if (vif.o_hcnt == 12'd8 && !seen8) begin chk("de_h8", 32'(vif.o_de), 0); seen8 = 1'b1; end
            if (vif.o_vsync && !prev_vs)
                chk("vs_rise", {vif.o_hcnt, vif.o_vcnt}, {12'd0, 12'd5});
            if (vif.o_frame_start) begin
                if (last_fs >= 0) chk("fs_period", c - last_fs, 128);
                last_fs = c;
            end
            if (vif.o_line_start) begin
                if (last_ls >= 0) chk("ls_period", c - last_ls, 16);
                last_ls = c;
            end
            hs_mask[vif.o_hcnt[3:0]] = hs_mask[vif.o_hcnt[3:0]] | vif.o_hsync;
            vs_mask[vif.o_vcnt[2:0]] = vs_mask[vif.o_vcnt[2:0]] | vif.o_vsync;
            prev_vs  = vif.o_vsync;
            prev_end = (vif.o_hcnt == 12'd15 && vif.o_vcnt == 12'd7);
        end
        chk("hs_window", 32'(hs_mask), 32'h1C00);
        chk("vs_window", 32'(vs_mask), 32'h60);

        // Hold at end of line, then resume without skipping a coordinate.
        wait_for(15, -1, 40, "hold_wait");
        v0 = int'(vif.o_vcnt);
        vif.i_en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("hold_cnt", {vif.o_hcnt, vif.o_vcnt}, {12'd15, 12'(v0)});
            chk("hold_pulses", {30'd0, vif.o_line_start, vif.o_frame_start}, 0);
        end
        vif.i_en = 1'b1;
        @(negedge clk);
        chk("resume", {vif.o_hcnt, vif.o_vcnt, vif.o_line_start}, {12'd0, 12'((v0 + 1) % VT), 1'b1});

        // Asynchronous reset between clock edges.
        wait_for(9, 5, 200, "arst_wait");
        #2 rst = 1'b1;
        #1 chk("arst_now", act, {12'd15, 12'd7, 5'b00000});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_restart", {vif.o_hcnt, vif.o_vcnt, vif.o_frame_start}, {12'd0, 12'd0, 1'b1});

        // Random enable pattern with occasional mid-cycle resets.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            vif.i_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end

        while (hd_cyc < 3400) @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator that produces the i_hcnt/i_vcnt pixel coordinates consumed by the tile renderer, plus HDMI/DVI sync and data-enable signals.
- Default timing is CEA 1280x720@60 on the 74.25 MHz pixel clock.
- Active video starts at count 0, so downstream tile logic can slice hcnt[10:5]/vcnt[10:5] directly.
- All outputs are registered and mutually aligned.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, visible lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- H_POL, 1, hsync active level (1 = active-high)
- V_POL, 1, vsync active level (1 = active-high)

Ports:
- i_clk_74M  input  1  pixel clock
- i_rst  input  1  asynchronous active-high reset
- i_en  input  1  advance enable; low freezes the raster
- o_hcnt  output  12  horizontal position, 0..H_TOTAL-1
- o_vcnt  output  12  vertical position, 0..V_TOTAL-1
- o_hsync  output  1  horizontal sync, level per H_POL
- o_vsync  output  1  vertical sync, level per V_POL
- o_de  output  1  data enable (active video)
- o_line_start  output  1  one-cycle pulse when o_hcnt becomes 0
- o_frame_start  output  1  one-cycle pulse when (o_hcnt,o_vcnt) becomes (0,0)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1650); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (750).
- Elaboration check: both totals must be ≤ 4096; every parameter except the polarities must be ≥ 1.
- Reset (async assert, sampled release):
  - o_hcnt = H_TOTAL-1, o_vcnt = V_TOTAL-1
  - o_hsync = ~H_POL, o_vsync = ~V_POL
  - o_de = 0, o_line_start = 0, o_frame_start = 0
- First enabled cycle after reset lands on (0,0) with o_frame_start=1, o_line_start=1, o_de=1.
- Advance (i_en=1), evaluated each clock:
  - If o_hcnt == H_TOTAL-1: o_hcnt <= 0.
    - If o_vcnt == V_TOTAL-1 then o_vcnt <= 0, else o_vcnt <= o_vcnt+1.
  - Otherwise: o_hcnt <= o_hcnt+1 and o_vcnt holds.
- Hold (i_en=0): counters, hsync, vsync and de hold their values; o_line_start and o_frame_start are forced to 0.
- Alignment rule: every output is computed from the next counter values and registered, so in any cycle the outputs describe the current (o_hcnt,o_vcnt). Zero latency between counters and decoded signals.
- Decoding (h = next hcnt, v = next vcnt):
  - de = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hsync active iff H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
  - vsync active iff V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC; changes only at h==0 (line-aligned)
  - line_start = advancing && h==0
  - frame_start = advancing && h==0 && v==0
- Wrap: counters never exceed H_TOTAL-1 / V_TOTAL-1. No state outside the two counters influences the next counter values.
- Reset mid-frame: all outputs immediately take their reset values; the next enabled cycle after release restarts at (0,0).
- Toggling i_en mid-line must not skip or repeat any coordinate.

Decomposition:
- Package video_timing_pkg holds:
  - CNT_W = 12
  - the 720p defaults as named constants (H_ACTIVE_720P, ...)
  - a tiny test timing set (TEST_*) for simulation
- One natural sub-module: wrap_counter (parameters MAX, W; ports clk, rst, inc, value, wrap).
  - Instantiated twice: horizontal counter with inc=i_en; vertical counter with inc=i_en && h_wrap.
  - Decode logic stays in the top.

Test Plan (bench uses H 8/2/3/3 → H_TOTAL=16, V 4/1/2/1 → V_TOTAL=8, H_POL=V_POL=1 unless noted):
- Reset, then i_en=1: cycle 1 shows hcnt=0, vcnt=0, de=1, frame_start=1, line_start=1; hcnt=7 has de=1; hcnt=8 has de=0.
- Sync windows: hsync=1 exactly for hcnt 10..12 on every line; vsync=1 exactly for vcnt 5..6, rising at hcnt=0 of line 5.
- Wrap: after (15,7) the next cycle is (0,0) with frame_start=1. frame_start occurs every 128 enabled cycles; line_start every 16.
- i_en low for 5 cycles at hcnt=15: all outputs hold, no pulses. On re-enable, (0,v+1) follows with line_start=1 and no coordinate skipped.
- Async reset asserted at (9,5) between clock edges: outputs go to (15,7), hsync=0, vsync=0, de=0 with no clock edge. After release, the sequence restarts at (0,0).
- 720p defaults with H_POL=V_POL=0: hsync is low for hcnt 1390..1429 and high otherwise; 1650×750 = 1,237,500 cycles between frame_start pulses; de-high count per frame = 921,600.
